// File: rtl/neuron_sched_pkg.sv
// Shared types and helpers for the neuron layer scheduler.
// Holds the FSM state enum, default widths and the address-width helper.
package neuron_sched_pkg;

   localparam int DEF_DATA_WIDTH  = 16;
   localparam int DEF_INPUT_WIDTH = 10;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } sched_state_t;

   function automatic int addr_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sched_result_buf.sv
// In-order layer result buffer: indexed write, write counter, full flag.
// The counter saturates at NUM_NEURONS; writes beyond that are dropped.
module sched_result_buf
   import neuron_sched_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int NUM_NEURONS = 8,
   parameter int CNT_W       = $clog2(NUM_NEURONS + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         wr_en,
   input  logic signed [DATA_WIDTH-1:0] wr_data,
   output logic [CNT_W-1:0]             cnt,
   output logic                         full,
   output logic signed [DATA_WIDTH-1:0] layer_out [NUM_NEURONS]
);

   localparam int IDX_W = addr_w(NUM_NEURONS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_NEURONS);

   assign full = (cnt == LAST);

   // store each accepted result at the next slot and advance the count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         for (int i = 0; i < NUM_NEURONS; i++) begin
            layer_out[i] <= '0;
         end
      end else if (clr) begin
         cnt <= '0;
      end else if (wr_en && !full) begin
         layer_out[IDX_W'(cnt)] <= wr_data;
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/neuron_layer_scheduler.sv
// Sequences one shared neuron datapath across all outputs of a layer.
// Optional drain watchdog and error flag: define NEURON_SCHED_WDOG_EN.
module neuron_layer_scheduler
   import neuron_sched_pkg::*;
#(
   parameter int INPUT_WIDTH    = DEF_INPUT_WIDTH,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int NUM_NEURONS    = 8,
   parameter int TIMEOUT_CYCLES = 64,
   localparam int ADDR_W        = addr_w(NUM_NEURONS)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic signed [DATA_WIDTH-1:0] act_in [INPUT_WIDTH],
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic                         w_rd_en,
   output logic [ADDR_W-1:0]            w_rd_addr,
   input  logic signed [DATA_WIDTH-1:0] w_rd_data [INPUT_WIDTH],
   input  logic signed [DATA_WIDTH-1:0] b_rd_data,
   output logic                         dp_valid_in,
   output logic signed [DATA_WIDTH-1:0] dp_a [INPUT_WIDTH],
   output logic signed [DATA_WIDTH-1:0] dp_w [INPUT_WIDTH],
   output logic signed [DATA_WIDTH-1:0] dp_bias,
   input  logic                         dp_valid_out,
   input  logic signed [DATA_WIDTH-1:0] dp_result,
   output logic signed [DATA_WIDTH-1:0] layer_out [NUM_NEURONS],
   output logic                         layer_valid
);

   localparam int CNT_W = $clog2(NUM_NEURONS + 1);
   localparam logic [CNT_W-1:0] N_CNT = CNT_W'(NUM_NEURONS);

   sched_state_t state;
   logic [CNT_W-1:0] iss_cnt;
   logic [CNT_W-1:0] rcv_cnt;
   logic buf_full;
   logic accept;
   logic capture;
   logic rcv_last;
   logic wd_fire;
   logic signed [DATA_WIDTH-1:0] act_q [INPUT_WIDTH];

   assign busy    = (state != IDLE);
   assign accept  = (state == IDLE) && start;
   assign capture = dp_valid_out && !buf_full
                    && (state == ISSUE || state == DRAIN);
   assign rcv_last = (rcv_cnt == N_CNT)
                     || (capture && rcv_cnt == N_CNT - CNT_W'(1));

   assign dp_a    = act_q;
   assign dp_w    = w_rd_data;
   assign dp_bias = b_rd_data;

   sched_result_buf #(
      .DATA_WIDTH  (DATA_WIDTH),
      .NUM_NEURONS (NUM_NEURONS),
      .CNT_W       (CNT_W)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .clr       (accept),
      .wr_en     (capture),
      .wr_data   (dp_result),
      .cnt       (rcv_cnt),
      .full      (buf_full),
      .layer_out (layer_out)
   );

`ifdef NEURON_SCHED_WDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] idle_cnt;
   logic strobe_ign;

   assign strobe_ign = dp_valid_out && !capture;
   assign wd_fire = (state == DRAIN) && !dp_valid_out
                    && (idle_cnt == WD_LAST);

   // count silent drain cycles; flag timeouts and stray strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (state != DRAIN || dp_valid_out || wd_fire) begin
            idle_cnt <= '0;
         end else begin
            idle_cnt <= idle_cnt + WD_W'(1);
         end
         if (strobe_ign || wd_fire) begin
            err <= 1'b1;
         end else if (accept) begin
            err <= 1'b0;
         end
      end
   end
`else
   logic unused_tmo;

   assign unused_tmo = (TIMEOUT_CYCLES > 0);
   assign wd_fire    = 1'b0;
   assign err        = 1'b0;
`endif

   // main sequencer: issue reads back-to-back, then wait for results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         iss_cnt     <= '0;
         w_rd_en     <= 1'b0;
         w_rd_addr   <= '0;
         dp_valid_in <= 1'b0;
         done        <= 1'b0;
         layer_valid <= 1'b0;
         for (int i = 0; i < INPUT_WIDTH; i++) begin
            act_q[i] <= '0;
         end
      end else begin
         dp_valid_in <= w_rd_en;
         done        <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  act_q       <= act_in;
                  layer_valid <= 1'b0;
                  w_rd_en     <= 1'b1;
                  w_rd_addr   <= '0;
                  iss_cnt     <= CNT_W'(1);
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (iss_cnt == N_CNT) begin
                  w_rd_en <= 1'b0;
                  state   <= DRAIN;
               end else begin
                  w_rd_addr <= ADDR_W'(iss_cnt);
                  iss_cnt   <= iss_cnt + CNT_W'(1);
               end
            end
            DRAIN: begin
               if (rcv_last) begin
                  done        <= 1'b1;
                  layer_valid <= 1'b1;
                  state       <= DONE;
               end else if (wd_fire) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/neuron_layer_scheduler.md
Name: neuron_layer_scheduler

Overview:
- Sequences one shared neuron+ReLU datapath across all NUM_NEURONS outputs of a layer.
- On start it latches the activation vector and reads each neuron's weight row and bias from a 1-cycle-latency weight ROM.
- Issues one dot-product per cycle to the datapath and collects the in-order results into a layer result buffer.
- Sits between the layer-level controller (start/done) and the neuron datapath.

Parameters:
- INPUT_WIDTH, 10, activations/weights per neuron
- DATA_WIDTH, 16, signed fixed-point word width
- NUM_NEURONS, 8, neurons in the layer (>=1)
- TIMEOUT_CYCLES, 64, drain watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request a layer pass; accepted only in IDLE
- act_in  in  [INPUT_WIDTH] x DATA_WIDTH signed  activation vector, sampled on accepted start
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when the layer completes
- err  out  1  sticky error flag (optional feature only, else tied 0)
- w_rd_en  out  1  weight ROM read enable
- w_rd_addr  out  ADDR_W  neuron index; ADDR_W = max(1, clog2(NUM_NEURONS))
- w_rd_data  in  [INPUT_WIDTH] x DATA_WIDTH signed  weight row, valid 1 cycle after w_rd_en
- b_rd_data  in  DATA_WIDTH signed  bias, same timing as w_rd_data
- dp_valid_in  out  1  issue strobe to the datapath
- dp_a  out  [INPUT_WIDTH] x DATA_WIDTH signed  latched activations
- dp_w  out  [INPUT_WIDTH] x DATA_WIDTH signed  pass-through of w_rd_data
- dp_bias  out  DATA_WIDTH signed  pass-through of b_rd_data
- dp_valid_out  in  1  datapath result strobe (post-ReLU)
- dp_result  in  DATA_WIDTH signed  datapath result
- layer_out  out  [NUM_NEURONS] x DATA_WIDTH signed  result buffer
- layer_valid  out  1  buffer holds a complete layer

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; all counters, busy, done, err, w_rd_en, dp_valid_in and layer_valid = 0.
  - layer_out entries and the activation latch = 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1: latch act_in, clear layer_valid, iss_cnt=0, rcv_cnt=0, go to ISSUE.
  - start in any other state is ignored.
- ISSUE:
  - w_rd_en=1 and w_rd_addr=iss_cnt, both registered; iss_cnt increments each cycle.
  - After the cycle issuing address NUM_NEURONS-1, go to DRAIN.
  - Result: exactly NUM_NEURONS consecutive read cycles, no gaps.
- dp_valid_in is w_rd_en delayed one cycle. dp_w and dp_bias are combinational from ROM data, so ROM data and strobe align. dp_a is the latched vector.
- Result capture (ISSUE or DRAIN):
  - On dp_valid_out, write layer_out[rcv_cnt] <= dp_result and increment rcv_cnt. Results are in order.
  - No ordering assumption on datapath latency (>=1 cycle); results may arrive while still in ISSUE.
- DRAIN: when rcv_cnt reaches NUM_NEURONS (including a strobe in the same cycle), go to DONE.
- DONE (1 cycle): done=1 and layer_valid set; layer_valid stays high until the next accepted start. Then go to IDLE.
- Timing: start accepted at cycle 0 → first w_rd_en at cycle 1 → first dp_valid_in at cycle 2.
  - With datapath latency L, done is asserted at cycle NUM_NEURONS+L+2.
- dp_valid_out while in IDLE or DONE, or when rcv_cnt==NUM_NEURONS: ignored. No buffer write, no counter change.
- Reset mid-operation aborts immediately to IDLE. The datapath shares rst, so there are no stale results.
- rcv_cnt is NUM_NEURONS+1 wide-capable, so no wrap at the limit.

Optional Feature:
- NEURON_SCHED_WDOG_EN defined:
  - In DRAIN, an idle counter resets on each dp_valid_out and increments otherwise.
  - When it reaches TIMEOUT_CYCLES: set err, go to DONE with layer_valid=0 and done pulsed.
  - A dp_valid_out that is ignored (see Behaviour) also sets err.
  - err is cleared only by rst or by an accepted start.
- Not defined: no watchdog logic; err tied 0; DRAIN waits indefinitely.

Decomposition:
- Package neuron_sched_pkg holds:
  - state enum sched_state_t {IDLE, ISSUE, DRAIN, DONE}
  - the addr-width function max(1,clog2(n))
  - default DATA_WIDTH/INPUT_WIDTH constants
- One natural sub-module, sched_result_buf: indexed write, write counter, full flag, parallel read-out of layer_out.

Test Plan:
- NUM_NEURONS=4, model datapath latency 3 returning 10,20,30,40:
  - w_rd_addr sequence 0,1,2,3 on cycles 1-4.
  - done at cycle 9; layer_out={10,20,30,40}; layer_valid=1.
- Negative results passed through (model returns -5): the value is stored as-is (-5), since the scheduler does no clamping.
- start held high through a whole pass: exactly one pass runs; a second pass starts only after returning to IDLE (cycle after done).
- rst asserted in ISSUE at iss_cnt=2:
  - All outputs return to reset values asynchronously.
  - A new start runs a full pass from address 0.
- dp_valid_out pulsed while IDLE with value 99: layer_out unchanged; err=1 only with NEURON_SCHED_WDOG_EN.
- With NEURON_SCHED_WDOG_EN and TIMEOUT_CYCLES=16, model drops the last result: err=1 and done pulses 16 cycles after the 3rd result; layer_valid=0.
